// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared by the pipelined ALU and its combinational core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_SRL = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_EQL = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU producing result, carry/borrow and signed overflow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; build option PIPELINED_ALU_SAT_EN makes ADD/SUB saturate unsigned.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SH_W-1:0]  shamt;

  // Extra top bit of the widened add/subtract is the carry-out or the borrow.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SH_W-1:0];

  // Opcode decode; flags stay low for anything that is not ADD/SUB.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
`ifdef PIPELINED_ALU_SAT_EN
        if (sum[WIDTH]) result = '1;
`endif
      end
      ALU_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
`ifdef PIPELINED_ALU_SAT_EN
        if (diff[WIDTH]) result = '0;
`endif
      end
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_EQL: result[0] = (a == b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage valid/ready ALU with tag pass-through, status flags and op counter.
// Latency: 2 cycles from input handshake to out_valid_o; sustains 1 op/cycle.
// Backpressure: S2 holds while stalled, S1 absorbs one more op, then in_ready_o drops (PIPELINED_ALU_SAT_EN selects saturating ADD/SUB).
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WIDTH-1:0]    alu_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                zero_o,
  output logic                carry_o,
  output logic                ovf_o,
  output logic [CNT_W-1:0]    op_count_o
);

  // Stage 1: captured operands
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: registered result presented on the outputs
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_zero;
  logic             s2_carry;
  logic             s2_ovf;
  logic [CNT_W-1:0] op_count;

  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;

  // S2 can take new data when empty or when its current result leaves this cycle.
  assign s2_free    = !s2_valid || out_ready_i;
  assign s1_adv     = s1_valid && s2_free;
  assign in_ready_o = !s1_valid || s2_free;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = s2_valid && out_ready_i;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_res),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  // Stage 1 register: load on input handshake, empty when advancing with nothing new behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= ALU_ADD;
      s1_tag   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a_i;
      s1_b     <= b_i;
      s1_op    <= alu_op_e'(op_i);
      s1_tag   <= tag_i;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: capture core output on advance; hold everything steady while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_tag   <= '0;
      s2_zero  <= 1'b0;
      s2_carry <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_res   <= core_res;
      s2_tag   <= s1_tag;
      s2_zero  <= (core_res == '0);
      s2_carry <= core_carry;
      s2_ovf   <= core_ovf;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid_o = s2_valid;
  assign alu_o       = s2_res;
  assign tag_o       = s2_tag;
  assign zero_o      = s2_zero;
  assign carry_o     = s2_carry;
  assign ovf_o       = s2_ovf;
  assign op_count_o  = op_count;

endmodule
